multicycle_alu: RTL and testbench

- Execution-stage ALU that consumes the 3-bit operation code produced by the ALU control decoder, plus two register operands.
- ADD, SUB, AND, OR, SLT and NOP complete in one cycle.
- MUL (shift-add) and DIV (restoring) are iterative and take WIDTH cycles.
- A START/BUSY/DONE handshake lets the pipeline control stall on long operations.

---
 rtl/multicycle_alu.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execution-stage ALU with single-cycle logic ops and iterative MUL/DIV
// START/BUSY/DONE handshake; all result outputs are registered.

module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] HI,
  output logic             ZERO,
  output logic             DZ,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_MUL,
    RUN_DIV
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // acc_hi/acc_lo: partial product (MUL) or remainder/quotient (DIV); opnd holds the fixed operand
  logic [WIDTH-1:0] acc_hi, acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;

  logic [WIDTH-1:0] res_nxt, hi_nxt;
  logic             zero_nxt, dz_nxt, done_nxt;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo;

  always_comb begin
    alu_res = '0;
    case (OP)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand if LSB set, then shift the {hi,lo} pair right.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // One restoring step: the difference fits WIDTH bits whenever the subtract is taken.
  always_comb begin
    div_sh = {acc_hi, acc_lo[WIDTH-1]};
    div_ok = (div_sh >= {1'b0, opnd});
    div_hi = div_ok ? (div_sh[WIDTH-1:0] - opnd) : div_sh[WIDTH-1:0];
    div_lo = {acc_lo[WIDTH-2:0], div_ok};
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    opnd_nxt   = opnd;
    res_nxt    = RES;
    hi_nxt     = HI;
    zero_nxt   = ZERO;
    dz_nxt     = DZ;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          case (OP)
            OP_MUL: begin
              state_nxt  = RUN_MUL;
              cnt_nxt    = '0;
              acc_hi_nxt = '0;
              acc_lo_nxt = B;
              opnd_nxt   = A;
            end
            OP_DIV: begin
              if (B == '0) begin
                res_nxt  = '1;
                hi_nxt   = A;
                zero_nxt = 1'b0;
                dz_nxt   = 1'b1;
                done_nxt = 1'b1;
              end else begin
                state_nxt  = RUN_DIV;
                cnt_nxt    = '0;
                acc_hi_nxt = '0;
                acc_lo_nxt = A;
                opnd_nxt   = B;
              end
            end
            OP_NOP: begin
              done_nxt = 1'b1;
            end
            default: begin
              res_nxt  = alu_res;
              hi_nxt   = '0;
              zero_nxt = (alu_res == '0);
              dz_nxt   = 1'b0;
              done_nxt = 1'b1;
            end
          endcase
        end
      end
      RUN_MUL: begin
        acc_hi_nxt = mul_hi;
        acc_lo_nxt = mul_lo;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          res_nxt   = mul_lo;
          hi_nxt    = mul_hi;
          zero_nxt  = (mul_lo == '0);
          dz_nxt    = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      RUN_DIV: begin
        acc_hi_nxt = div_hi;
        acc_lo_nxt = div_lo;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          res_nxt   = div_lo;
          hi_nxt    = div_hi;
          zero_nxt  = (div_lo == '0);
          dz_nxt    = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      RES    <= '0;
      HI     <= '0;
      ZERO   <= 1'b0;
      DZ     <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc_hi <= acc_hi_nxt;
      acc_lo <= acc_lo_nxt;
      opnd   <= opnd_nxt;
      RES    <= res_nxt;
      HI     <= hi_nxt;
      ZERO   <= zero_nxt;
      DZ     <= dz_nxt;
      DONE   <= done_nxt;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - randomized self-checking bench for multicycle_alu
// Reference results come from plain arithmetic on 64-bit values.

module tb_multicycle_alu;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] RES;
  logic [31:0] HI;
  logic        ZERO;
  logic        DZ;
  logic        BUSY;
  logic        DONE;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_res;
  logic [31:0] m_hi;
  logic        m_zero;
  logic        m_dz;

  multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .RES(RES), .HI(HI), .ZERO(ZERO), .DZ(DZ), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Applies an op to the architectural model and returns the expected BUSY cycle count.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int exp_busy);
    logic [63:0] p;
    exp_busy = 0;
    case (op)
      3'd0: m_res = a + b;
      3'd1: m_res = a - b;
      3'd2: m_res = a & b;
      3'd3: m_res = a | b;
      3'd4: m_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: ;
    endcase
    if (op <= 3'd4) begin
      m_hi = 0; m_dz = 0; m_zero = (m_res == 0);
    end else if (op == 3'd5) begin
      p = {32'd0, a} * {32'd0, b};
      m_res = p[31:0]; m_hi = p[63:32]; m_dz = 0; m_zero = (m_res == 0);
      exp_busy = 32;
    end else if (op == 3'd6) begin
      if (b == 0) begin
        m_res = 32'hFFFF_FFFF; m_hi = a; m_dz = 1; m_zero = 0;
      end else begin
        m_res = a / b; m_hi = a % b; m_dz = 0; m_zero = (m_res == 0);
        exp_busy = 32;
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    OP = op; A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    OP = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".res"},  64'(RES),  64'(m_res));
    check({tag, ".hi"},   64'(HI),   64'(m_hi));
    check({tag, ".zero"}, 64'(ZERO), 64'(m_zero));
    check({tag, ".dz"},   64'(DZ),   64'(m_dz));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int exp_busy;
    int busy_cnt;
    int cyc;
    model_apply(op, a, b, exp_busy);
    issue(op, a, b);
    busy_cnt = 0;
    cyc = 0;
    forever begin
      @(negedge CLK);
      if (DONE || cyc > 100) break;
      if (BUSY) busy_cnt++;
      cyc++;
    end
    check({tag, ".done"}, 64'(DONE), 64'd1);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, ".busy_at_done"}, 64'(BUSY), 64'd0);
    check_outputs(tag);
    @(negedge CLK);
    check({tag, ".done_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int dummy;
    int done_cnt;
    int cyc;
    logic [31:0] seen_res;
    logic [31:0] seen_hi;

    RST = 1'b1; START = 1'b0; OP = 3'd0; A = 0; B = 0;
    m_res = 0; m_hi = 0; m_zero = 0; m_dz = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("reset.done", 64'(DONE), 64'd0);
    check("reset.busy", 64'(BUSY), 64'd0);
    check_outputs("reset");

    run_op("add", 3'd0, 32'd5, 32'd7);
    run_op("sub", 3'd1, 32'd3, 32'd5);
    run_op("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd1);
    run_op("slt_pos", 3'd4, 32'd1, 32'hFFFF_FFFF);
    run_op("mul_a", 3'd5, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_b", 3'd5, 32'hFFFF_FFFF, 32'd2);
    run_op("div_a", 3'd6, 32'd100, 32'd7);
    run_op("div_z", 3'd6, 32'd9, 32'd0);
    run_op("nop", 3'd7, 32'd1, 32'd2);
    run_op("div_big", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // START during a MUL must not disturb it or produce an extra DONE.
    model_apply(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, dummy);
    issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge CLK);
    OP = 3'd0; A = 32'd1; B = 32'd1; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    done_cnt = 0; seen_res = 0; seen_hi = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) begin
        done_cnt++; seen_res = RES; seen_hi = HI;
      end
    end
    check("stress.done_count", 64'(done_cnt), 64'd1);
    check("stress.res", 64'(seen_res), 64'(m_res));
    check("stress.hi", 64'(seen_hi), 64'(m_hi));

    // Back-to-back issue in the DONE cycle.
    model_apply(3'd5, 32'd3, 32'd4, dummy);
    issue(3'd5, 32'd3, 32'd4);
    cyc = 0;
    forever begin
      @(negedge CLK);
      if (DONE || cyc > 100) break;
      cyc++;
    end
    check("b2b.mul_done", 64'(DONE), 64'd1);
    check_outputs("b2b.mul");
    OP = 3'd0; A = 32'd1; B = 32'd1; START = 1'b1;
    model_apply(3'd0, 32'd1, 32'd1, dummy);
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    check("b2b.add_done", 64'(DONE), 64'd1);
    check_outputs("b2b.add");

    // Reset in the middle of a DIV aborts it silently.
    issue(3'd6, 32'd100, 32'd7);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_res = 0; m_hi = 0; m_zero = 0; m_dz = 0;
    @(negedge CLK);
    check("rst_mid.done", 64'(DONE), 64'd0);
    check("rst_mid.busy", 64'(BUSY), 64'd0);
    check_outputs("rst_mid");
    done_cnt = 0;
    repeat (35) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
    check("rst_mid.no_done", 64'(done_cnt), 64'd0);
    run_op("rst_mid.add", 3'd0, 32'd20, 32'd22);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 15);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
